// File: rtl/yuv_to_yuyv_if.sv
// Pixel-in / byte-out stream bundle for the YUV444 to YUYV 4:2:2 packer.
interface yuv_to_yuyv_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic [3*DATA_WIDTH-1:0] data_in;
  logic                    in_valid;
  logic                    in_sof;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_sof;
  logic                    pair_err;
  logic [CNT_WIDTH-1:0]    pair_cnt;

  modport master (
    output data_in, in_valid, in_sof, out_ready,
    input  in_ready, data_out, out_valid, out_sof, pair_err, pair_cnt
  );

  modport slave (
    input  data_in, in_valid, in_sof, out_ready,
    output in_ready, data_out, out_valid, out_sof, pair_err, pair_cnt
  );
endinterface

// File: rtl/yuv_to_yuyv.sv
// Packs pairs of YUV444 pixels into a Y0 U Y1 V byte stream with rounded
// chroma averaging, frame-start tracking and odd-pixel detection.
module yuv_to_yuyv #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  yuv_to_yuyv_if.slave bus
);

  localparam logic [2:0] S_P0 = 3'd0;
  localparam logic [2:0] S_P1 = 3'd1;
  localparam logic [2:0] S_Y0 = 3'd2;
  localparam logic [2:0] S_U  = 3'd3;
  localparam logic [2:0] S_Y1 = 3'd4;
  localparam logic [2:0] S_V  = 3'd5;

  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] y0, u0, v0, y1, u_avg, v_avg;
  logic                  sof_flag;
  logic                  pair_err_q;
  logic [CNT_WIDTH-1:0]  pair_cnt_q;
  logic [DATA_WIDTH-1:0] data_out_c;

  logic [DATA_WIDTH-1:0] in_y, in_u, in_v;
  logic [DATA_WIDTH:0]   sum_u, sum_v;
  logic                  in_ready_c, out_valid_c, in_xfer, out_xfer;

  assign in_y = bus.data_in[3*DATA_WIDTH-1:2*DATA_WIDTH];
  assign in_u = bus.data_in[2*DATA_WIDTH-1:DATA_WIDTH];
  assign in_v = bus.data_in[DATA_WIDTH-1:0];

  // One extra bit keeps the +1 rounding from wrapping at full scale.
  assign sum_u = {1'b0, u0} + {1'b0, in_u} + {{DATA_WIDTH{1'b0}}, 1'b1};
  assign sum_v = {1'b0, v0} + {1'b0, in_v} + {{DATA_WIDTH{1'b0}}, 1'b1};

  assign in_ready_c  = (state == S_P0) || (state == S_P1);
  assign out_valid_c = (state == S_Y0) || (state == S_U) ||
                       (state == S_Y1) || (state == S_V);
  assign in_xfer     = bus.in_valid && in_ready_c;
  assign out_xfer    = out_valid_c && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_P0;
      y0         <= '0;
      u0         <= '0;
      v0         <= '0;
      y1         <= '0;
      u_avg      <= '0;
      v_avg      <= '0;
      sof_flag   <= 1'b0;
      pair_err_q <= 1'b0;
      pair_cnt_q <= '0;
    end else if (clear) begin
      state      <= S_P0;
      y0         <= '0;
      u0         <= '0;
      v0         <= '0;
      y1         <= '0;
      u_avg      <= '0;
      v_avg      <= '0;
      sof_flag   <= 1'b0;
      pair_err_q <= 1'b0;
      pair_cnt_q <= '0;
    end else begin
      pair_err_q <= 1'b0;
      case (state)
        S_P0: if (in_xfer) begin
          y0       <= in_y;
          u0       <= in_u;
          v0       <= in_v;
          sof_flag <= bus.in_sof;
          if (bus.in_sof) pair_cnt_q <= '0;
          state    <= S_P1;
        end
        S_P1: if (in_xfer) begin
          if (bus.in_sof) begin
            // New frame started mid-pair: the lone pixel 0 is dropped.
            y0         <= in_y;
            u0         <= in_u;
            v0         <= in_v;
            sof_flag   <= 1'b1;
            pair_err_q <= 1'b1;
            pair_cnt_q <= '0;
          end else begin
            y1    <= in_y;
            u_avg <= sum_u[DATA_WIDTH:1];
            v_avg <= sum_v[DATA_WIDTH:1];
            state <= S_Y0;
          end
        end
        S_Y0: if (out_xfer) state <= S_U;
        S_U:  if (out_xfer) state <= S_Y1;
        S_Y1: if (out_xfer) state <= S_V;
        S_V:  if (out_xfer) begin
          pair_cnt_q <= pair_cnt_q + CNT_WIDTH'(1);
          state      <= S_P0;
        end
        default: state <= S_P0;
      endcase
    end
  end

  always_comb begin
    data_out_c = '0;
    case (state)
      S_Y0:    data_out_c = y0;
      S_U:     data_out_c = u_avg;
      S_Y1:    data_out_c = y1;
      S_V:     data_out_c = v_avg;
      default: data_out_c = '0;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.data_out  = data_out_c;
  assign bus.out_sof   = (state == S_Y0) && sof_flag;
  assign bus.pair_err  = pair_err_q;
  assign bus.pair_cnt  = pair_cnt_q;

endmodule
